// File: rtl/seq_rot.sv
// Sequential N-bit rotator: rotates one bit position per clock through a
// start/busy/done handshake and holds the last result on a registered output.
module seq_rot #(
  parameter int AW = 2,
  parameter int N  = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          dir,
  input  logic [N-1:0]  A,
  input  logic [AW-1:0] rotamt,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  Y
);

  if (N != (1 << AW)) begin : g_bad_width
    $error("seq_rot: N must equal 2**AW");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ROT  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [AW-1:0] CNT_ONE = AW'(1);

  state_t        state_q, state_d;
  logic [N-1:0]  sr_q, sr_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          dir_q, dir_d;
  logic [N-1:0]  y_q, y_d;
  logic [N-1:0]  rot_s;

  // Single-position rotate: 0 = left, 1 = right.
  function automatic logic [N-1:0] rot1(input logic [N-1:0] v, input logic right);
    logic [N-1:0] r;
    if (right) begin
      r = {v[0], v[N-1:1]};
    end else begin
      r = {v[N-2:0], v[N-1]};
    end
    return r;
  endfunction

  assign rot_s = rot1(sr_q, dir_q);

  // Next-state and datapath update for the IDLE/ROT/DONE sequencer.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    y_d     = y_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sr_d  = A;
          cnt_d = rotamt;
          dir_d = dir;
          if (rotamt == '0) begin
            y_d     = A;
            state_d = S_DONE;
          end else begin
            state_d = S_ROT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ROT: begin
        sr_d  = rot_s;
        cnt_d = cnt_q - CNT_ONE;
        // Exiting at cnt==1 keeps cnt from ever wrapping below zero.
        if (cnt_q == CNT_ONE) begin
          y_d     = rot_s;
          state_d = S_DONE;
        end else begin
          state_d = S_ROT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; synchronous reset aborts any operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      y_q     <= y_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign Y    = y_q;

endmodule
